// File: rtl/dmem_arbiter.sv
// dmem_arbiter: 16x8 single-port data memory shared by two requesters through a
// round-robin arbiter (port 0 = processor load/store, port 1 = loader/debug).
// Ports: clk, rst (sync, active-high);
//        reqN/weN/addrN/wdataN in, gntN/rvalidN/rdataN out for N = 0,1;
//        err  - pulse in RESP when the granted access was out of range;
//        busy - high whenever the FSM is not IDLE.
// Build option: define DMEM_PRELOAD_EN to have reset load the demo operands
// (mem[0]=EC, mem[1]=0A, mem[2]=02, rest 0); otherwise memory survives reset.
module dmem_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic              busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              last;
    logic              win;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic              pick;
    logic              wr;
    logic [DATA_W-1:0] rd_word;

    // On a tie the port that was not served last wins; a lone request always wins.
    assign pick     = (req0 && req1) ? !last : req1;
    assign in_range = l_addr < LIMIT;
    assign wr       = (state == ACCESS) && l_we && in_range;
    assign rd_word  = in_range ? mem[l_addr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
`ifdef DMEM_PRELOAD_EN
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem[0] <= DATA_W'(8'hEC);
            mem[1] <= DATA_W'(8'h0A);
            mem[2] <= DATA_W'(8'h02);
        end else
`endif
        // A write whose ACCESS cycle coincides with reset is abandoned.
        if (!rst && wr) mem[l_addr[AW-1:0]] <= l_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            win     <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    state   <= ACCESS;
                    busy    <= 1'b1;
                    win     <= pick;
                    last    <= pick;
                    l_we    <= pick ? we1 : we0;
                    l_addr  <= pick ? addr1 : addr0;
                    l_wdata <= pick ? wdata1 : wdata0;
                    gnt0    <= !pick;
                    gnt1    <= pick;
                end
                ACCESS: begin
                    state <= RESP;
                    err   <= !in_range;
                    if (!l_we && !win) begin
                        rvalid0 <= 1'b1;
                        rdata0  <= rd_word;
                    end
                    if (!l_we && win) begin
                        rvalid1 <= 1'b1;
                        rdata1  <= rd_word;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter; a transaction-level model
// predicts grant/response events per cycle and a monitor compares every cycle.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       gnt0, rvalid0, gnt1, rvalid1, err, busy;
    logic [7:0] rdata0, rdata1;

    int compared = 0;
    int mismatched = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         resp;
        bit         p;
        bit         rd;
        logic [7:0] data;
        bit         err;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         free_at = 0;
    bit         last = 1'b1;
    logic [7:0] mmem [16];
    logic [7:0] exp_rd [2];
    bit         pw_valid = 1'b0;
    int         pw_at = 0;
    logic [7:0] pw_addr, pw_data;

    // Model: the memory is free again 3 edges after an arbitration; a write
    // lands on the edge after arbitration unless reset is high on that edge.
    always @(posedge clk) begin
        bit p, w, oor;
        logic [7:0] a, d;
        cyc++;
        if (pw_valid && pw_at == cyc) begin
            if (!rst) mmem[pw_addr[3:0]] = pw_data;
            pw_valid = 1'b0;
        end
        if (rst) begin
            q.delete();
            pw_valid = 1'b0;
            free_at = cyc + 1;
            last = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
`ifdef DMEM_PRELOAD_EN
            for (int i = 0; i < 16; i++) mmem[i] = '0;
            mmem[0] = 8'hEC;
            mmem[1] = 8'h0A;
            mmem[2] = 8'h02;
`endif
        end else if (cyc >= free_at && (req0 || req1)) begin
            p = (req0 && req1) ? !last : req1;
            last = p;
            w = p ? we1 : we0;
            a = p ? addr1 : addr0;
            d = p ? wdata1 : wdata0;
            oor = a >= 8'd16;
            q.push_back('{cyc, 1'b0, p, 1'b0, 8'h00, 1'b0});
            q.push_back('{cyc + 1, 1'b1, p, !w, oor ? 8'h00 : mmem[a[3:0]], oor});
            if (w && !oor) begin
                pw_valid = 1'b1;
                pw_at = cyc + 1;
                pw_addr = a;
                pw_data = d;
            end
            free_at = cyc + 3;
        end
    end

    // Monitor: expected outputs for the current cycle, compared away from the edge.
    always @(negedge clk) begin
        logic [1:0] eg, ev;
        logic       ee, eb;
        ev_t        e;
        eg = '0; ev = '0; ee = 1'b0; eb = 1'b0;
        while (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            eb = 1'b1;
            if (!e.resp) eg[e.p] = 1'b1;
            else begin
                ee = e.err;
                if (e.rd) begin
                    ev[e.p] = 1'b1;
                    exp_rd[e.p] = e.data;
                end
            end
        end
        if (cyc >= 1) begin
            compared++;
            if ({gnt0, gnt1, rvalid0, rvalid1, err, busy, rdata0, rdata1} !==
                {eg[0], eg[1], ev[0], ev[1], ee, eb, exp_rd[0], exp_rd[1]}) begin
                mismatched++;
                $display("FAIL cycle %0d outputs: got gnt=%b%b rvalid=%b%b err=%b busy=%b rdata0=%h rdata1=%h, want gnt=%b%b rvalid=%b%b err=%b busy=%b rdata0=%h rdata1=%h",
                         cyc, gnt0, gnt1, rvalid0, rvalid1, err, busy, rdata0, rdata1,
                         eg[0], eg[1], ev[0], ev[1], ee, eb, exp_rd[0], exp_rd[1]);
            end
        end
    end

    task automatic acc(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
        bit p0, p1;
        int n;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        p0 = r0; p1 = r1; n = 0;
        while ((p0 || p1) && n < 30) begin
            @(negedge clk);
            n++;
            if (p0 && gnt0) begin p0 = 1'b0; req0 = 1'b0; end
            if (p1 && gnt1) begin p1 = 1'b0; req1 = 1'b0; end
        end
        compared++;
        if (p0 || p1) begin
            mismatched++;
            $display("FAIL grant_timeout: pending p0=%b p1=%b after %0d cycles, want none", p0, p1, n);
            req0 = 1'b0; req1 = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) acc(0, 0, 0, 0, 1, 1, 8'(i), 8'($urandom));
        acc(0, 0, 0, 0, 1, 1, 8'd1, 8'h0A);
        acc(1, 0, 8'd1, 0, 0, 0, 0, 0);
        acc(0, 0, 0, 0, 1, 1, 8'd0, 8'h55);
        acc(1, 0, 8'd0, 0, 1, 0, 8'd0, 0);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'd1;
        repeat (14) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        acc(1, 0, 8'd20, 0, 0, 0, 0, 0);
        acc(0, 0, 0, 0, 1, 1, 8'd20, 8'h99);
        acc(1, 0, 8'd4, 0, 0, 0, 0, 0);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd3; wdata1 = 8'h77;
        n = 0;
        while (!gnt1 && n < 30) begin @(negedge clk); n++; end
        compared++;
        if (!gnt1) begin
            mismatched++;
            $display("FAIL rst_access_grant: gnt1=%b, want 1", gnt1);
        end
        req1 = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        acc(1, 0, 8'd3, 0, 1, 0, 8'd3, 0);
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (!req0 || gnt0) begin
                req0 = ($urandom % 3) != 0; we0 = 1'($urandom);
                addr0 = 8'($urandom_range(0, 19)); wdata0 = 8'($urandom);
            end
            if (!req1 || gnt1) begin
                req1 = ($urandom % 3) != 0; we1 = 1'($urandom);
                addr1 = 8'($urandom_range(0, 19)); wdata1 = 8'($urandom);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
        acc(0, 0, 0, 0, 1, 1, 8'd1, 8'h3C);
        pulse_rst();
        acc(1, 0, 8'd0, 0, 0, 0, 0, 0);
        acc(1, 0, 8'd1, 0, 0, 0, 0, 0);
        acc(1, 0, 8'd2, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
